mem_burst_ctrl: RTL and testbench

MEM_BURST_CTRL -- requirements
Module: mem_burst_ctrl

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_array.sv | 24 ++
 rtl/mem_burst_ctrl.sv | 118 +++++++++++
 tb/tb_mem_burst_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Types and constants shared by the burst memory controller and the cache controller.
package mem_pkg;

    localparam int unsigned WORD_SIZE_BIT            = 32;
    localparam int unsigned DEFAULT_BLOCK_SIZE_WORDS = 4;

    typedef enum logic [1:0] {
        IDLE,
        LATENCY,
        BURST,
        DONE
    } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Word-wide storage: synchronous write port, combinational read port, no reset.
module mem_array #(
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_burst_ctrl.sv
// Block-burst memory controller: fixed access latency, then one word per cycle for a block.
module mem_burst_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned MEM_DEPTH_WORDS  = 4096,
    parameter int unsigned BLOCK_SIZE_WORDS = DEFAULT_BLOCK_SIZE_WORDS,
    parameter int unsigned ACCESS_LATENCY   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              addr_mem,
    input  logic                     read_mem,
    input  logic                     write_mem,
    input  logic [WORD_SIZE_BIT-1:0] data_mem_in,
    output logic [WORD_SIZE_BIT-1:0] data_mem_out,
    output logic                     ready_mem
);

    localparam int unsigned ADDR_W = $clog2(MEM_DEPTH_WORDS);
    localparam int unsigned BEAT_W = (BLOCK_SIZE_WORDS > 1) ? $clog2(BLOCK_SIZE_WORDS) : 1;
    localparam int unsigned LAT_W  = 4;

    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BLOCK_SIZE_WORDS - 1);
    localparam logic [LAT_W-1:0]  LAT_LOAD   = LAT_W'(ACCESS_LATENCY - 1);
    localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'(BLOCK_SIZE_WORDS - 1);

    mem_state_t        state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              is_write_q, is_write_d;

    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_addr;
    logic [WORD_SIZE_BIT-1:0] mem_rdata;

    // Bits above the memory depth are discarded, which gives the modulo wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_mem[31:ADDR_W];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            lat_q      <= '0;
            beat_q     <= '0;
            base_q     <= '0;
            is_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            beat_q     <= beat_d;
            base_q     <= base_d;
            is_write_q <= is_write_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        beat_d     = beat_q;
        base_d     = base_q;
        is_write_d = is_write_q;
        ready_mem  = 1'b0;
        mem_we     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (read_mem || write_mem) begin
                    base_d     = addr_mem[ADDR_W-1:0] & BLOCK_MASK;
                    is_write_d = write_mem;
                    lat_d      = LAT_LOAD;
                    beat_d     = '0;
                    state_d    = LATENCY;
                end
            end
            LATENCY: begin
                if (lat_q == '0) begin
                    state_d = BURST;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            BURST: begin
                ready_mem = 1'b1;
                // Reset is synchronous, so the write must be blocked on the reset edge itself.
                mem_we    = is_write_q && reset;
                if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    state_d = DONE;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_addr     = base_q + ADDR_W'(beat_q);
    assign data_mem_out = (state_q == BURST && !is_write_q) ? mem_rdata : '0;

    mem_array #(
        .DEPTH  (MEM_DEPTH_WORDS),
        .WIDTH  (WORD_SIZE_BIT),
        .ADDR_W (ADDR_W)
    ) u_mem_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (data_mem_in),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed and randomized bench for mem_burst_ctrl against a word-indexed memory model.
module tb_mem_burst_ctrl;

    localparam int unsigned DEPTH  = 4096;
    localparam int unsigned BLK    = 4;
    localparam int unsigned LAT    = 4;
    localparam int unsigned PERIOD = LAT + BLK + 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr_mem;
    logic        read_mem;
    logic        write_mem;
    logic [31:0] data_mem_in;
    logic [31:0] data_mem_out;
    logic        ready_mem;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] model [int];
    logic [31:0] wbuf  [BLK];

    always #5 clk = ~clk;

    mem_burst_ctrl #(
        .MEM_DEPTH_WORDS  (DEPTH),
        .BLOCK_SIZE_WORDS (BLK),
        .ACCESS_LATENCY   (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .addr_mem     (addr_mem),
        .read_mem     (read_mem),
        .write_mem    (write_mem),
        .data_mem_in  (data_mem_in),
        .data_mem_out (data_mem_out),
        .ready_mem    (ready_mem)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Block-aligned base plus beat, reduced modulo the memory depth.
    function automatic int word_idx(input logic [31:0] addr, input int k);
        logic [31:0] base;
        base = addr - (addr % BLK);
        return int'((64'(base) + 64'(k)) % 64'(DEPTH));
    endfunction

    // One transaction from an idle controller. Expected timing comes straight from the
    // protocol: LAT dead cycles, BLK beats, one closing cycle.
    task automatic txn(input bit wr, input bit rd, input logic [31:0] addr,
                       input int drop_at, input int chg_at, input logic [31:0] alt_addr,
                       input int abort_at, input string tag);
        bit beat;
        int k;
        int idx;
        @(negedge clk);
        check({tag, ":idle_rdy"}, {31'b0, ready_mem}, 32'd0);
        read_mem  = rd;
        write_mem = wr;
        addr_mem  = addr;
        @(posedge clk);
        for (int c = 0; c <= int'(LAT + BLK); c++) begin
            @(negedge clk);
            if (c == drop_at) begin
                read_mem  = 1'b0;
                write_mem = 1'b0;
            end
            if (c == chg_at) addr_mem = alt_addr;
            beat = (c >= int'(LAT)) && (c < int'(LAT + BLK));
            check($sformatf("%s:rdy%0d", tag, c), {31'b0, ready_mem}, {31'b0, beat});
            if (!beat || wr) check($sformatf("%s:dout0_%0d", tag, c), data_mem_out, 32'd0);
            if (beat) begin
                k   = c - int'(LAT);
                idx = word_idx(addr, k);
                if (wr) begin
                    data_mem_in = wbuf[k];
                    if (c != abort_at) model[idx] = wbuf[k];
                end else if (model.exists(idx)) begin
                    check($sformatf("%s:data%0d", tag, k), data_mem_out, model[idx]);
                end
            end
            if (c == abort_at) begin
                reset = 1'b0;
                @(negedge clk);
                check({tag, ":abort_rdy"}, {31'b0, ready_mem}, 32'd0);
                check({tag, ":abort_dout"}, data_mem_out, 32'd0);
                reset = 1'b1;
                return;
            end
        end
        data_mem_in = $urandom();
    endtask

    initial begin
        int          rises[$];
        bit          prev;
        bit          exp_rdy;
        int          ph;
        logic [31:0] a;
        logic [31:0] a2;

        reset       = 1'b0;
        addr_mem    = '0;
        read_mem    = 1'b0;
        write_mem   = 1'b0;
        data_mem_in = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rdy", {31'b0, ready_mem}, 32'd0);
        check("reset_dout", data_mem_out, 32'd0);
        reset = 1'b1;

        // Preload 0x100..0x103, then read from an unaligned address in that block.
        wbuf = '{32'h000000A0, 32'h000000A1, 32'h000000A2, 32'h000000A3};
        txn(1'b1, 1'b0, 32'h100, 0, -1, 32'h0, -1, "pre100");
        txn(1'b0, 1'b1, 32'h102, 0, -1, 32'h0, -1, "rd102");

        wbuf = '{32'h11, 32'h22, 32'h33, 32'h44};
        txn(1'b1, 1'b0, 32'h200, 0, -1, 32'h0, -1, "wr200");
        txn(1'b0, 1'b1, 32'h200, 0, -1, 32'h0, -1, "rd200");

        // Both requests high: must act as a write.
        wbuf = '{32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003, 32'hCAFE0004};
        txn(1'b1, 1'b1, 32'h40, 0, -1, 32'h0, -1, "both40");
        txn(1'b0, 1'b1, 32'h40, 0, -1, 32'h0, -1, "rd40");

        // Distinct data at 0x300 so a mid-burst address change would be visible.
        wbuf = '{32'h30000000, 32'h30000001, 32'h30000002, 32'h30000003};
        txn(1'b1, 1'b0, 32'h300, 0, -1, 32'h0, -1, "pre300");
        txn(1'b0, 1'b1, 32'h200, 1, -1, 32'h0, -1, "drop1");
        txn(1'b0, 1'b1, 32'h100, 0, int'(LAT) + 1, 32'h300, -1, "chgaddr");
        wbuf = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
        txn(1'b1, 1'b0, 32'h201, 1, int'(LAT), 32'h300, -1, "wrchg");
        txn(1'b0, 1'b1, 32'h300, 0, -1, 32'h0, -1, "rd300");
        txn(1'b0, 1'b1, 32'h200, 0, -1, 32'h0, -1, "rd200b");

        // Reset during beat 2 of a write: only beats 0 and 1 land.
        wbuf = '{32'h80808080, 32'h81818181, 32'h82828282, 32'h83838383};
        txn(1'b1, 1'b0, 32'h80, 0, -1, 32'h0, -1, "pre80");
        wbuf = '{32'h5A5A0000, 32'h5A5A0001, 32'h5A5A0002, 32'h5A5A0003};
        txn(1'b1, 1'b0, 32'h80, 0, -1, 32'h0, int'(LAT) + 2, "abort80");
        txn(1'b0, 1'b1, 32'h80, 0, -1, 32'h0, -1, "rd80");

        // Out-of-range address wraps onto words 4..7.
        wbuf = '{32'h44440004, 32'h44440005, 32'h44440006, 32'h44440007};
        txn(1'b1, 1'b0, 32'h4, 0, -1, 32'h0, -1, "pre4");
        txn(1'b0, 1'b1, DEPTH + 4, 0, -1, 32'h0, -1, "wraprd");
        wbuf = '{32'h77770004, 32'h77770005, 32'h77770006, 32'h77770007};
        txn(1'b1, 1'b0, DEPTH + 6, 0, -1, 32'h0, -1, "wrapwr");
        txn(1'b0, 1'b1, 32'h4, 0, -1, 32'h0, -1, "rd4");

        // Read held high: back-to-back transactions, one every PERIOD cycles.
        @(negedge clk);
        read_mem = 1'b1;
        addr_mem = 32'h100;
        @(posedge clk);
        prev = 1'b0;
        for (int c = 0; c < int'(2 * PERIOD); c++) begin
            @(negedge clk);
            if (c == int'(2 * PERIOD) - 1) read_mem = 1'b0;
            ph      = c % int'(PERIOD);
            exp_rdy = (ph >= int'(LAT)) && (ph < int'(LAT + BLK));
            check($sformatf("b2b:rdy%0d", c), {31'b0, ready_mem}, {31'b0, exp_rdy});
            if (exp_rdy) begin
                check($sformatf("b2b:data%0d", c), data_mem_out,
                      model[word_idx(32'h100, ph - int'(LAT))]);
            end
            if (ready_mem && !prev) rises.push_back(c);
            prev = ready_mem;
        end
        check("b2b_rises", 32'(rises.size()), 32'd2);
        if (rises.size() == 2) check("b2b_gap", 32'(rises[1] - rises[0]), PERIOD);

        // Random write-then-read pairs, including wrapped aliases and early drops.
        for (int i = 0; i < 12; i++) begin
            a = 32'($urandom_range(0, 2 * DEPTH - 1));
            foreach (wbuf[j]) wbuf[j] = $urandom();
            txn(1'b1, 1'($urandom_range(0, 1)), a, int'($urandom_range(0, LAT + BLK)), -1,
                32'h0, -1, "rnd_wr");
            a2 = (a & ~32'(BLK - 1)) + 32'($urandom_range(0, BLK - 1))
                 + 32'(DEPTH) * 32'($urandom_range(0, 2));
            txn(1'b0, 1'b1, a2, int'($urandom_range(0, LAT + BLK)), int'(LAT),
                32'($urandom()), -1, "rnd_rd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
